// File: rtl/i2s_pkg.sv
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants, state encoding and the bit-clock divider
//               helper for the I2S transmit sequencer.
// Contents    : SAMPLE_W, FRAME_BITS, CNT_W, seq_state_t {IDLE, RUN},
//               calc_div_half()
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // System clocks per BCK half period, integer-truncated.
    function automatic int calc_div_half(input int clk_hz, input int bck_hz);
        return clk_hz / (2 * bck_hz);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_bck_tick_gen.sv
// ============================================================================
// Module      : i2s_bck_tick_gen
// Description : Divides the system clock down to the I2S bit clock. The
//               divider counts 0..DIV_HALF-1 and toggles BCK on every wrap.
//               fall_tick marks the system-clock edge on which BCK falls.
//               While i_run is low the divider is cleared and BCK held low,
//               so the first rising edge comes DIV_HALF clocks after i_run
//               goes high.
// Ports       : clk         in   system clock
//               reset       in   asynchronous active-high reset
//               i_run       in   1 = divide, 0 = hold/clear
//               o_bck       out  registered bit clock
//               o_fall_tick out  one-clk strobe, BCK falls on this edge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_bck_tick_gen #(
    parameter int DIV_HALF = 35
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_bck,
    output logic o_fall_tick
);

    localparam int c_div_w = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV_HALF - 1);

    logic [c_div_w-1:0] r_div;
    logic               r_bck;
    logic               w_wrap;

    assign w_wrap = i_run && (r_div == c_div_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else if (!i_run) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_bck <= ~r_bck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_bck       = r_bck;
    assign o_fall_tick = w_wrap && r_bck;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_sequencer.sv
// ============================================================================
// Module      : i2s_tx_sequencer
// Description : Frame-aware I2S transmitter. Derives BCK/LRCK from clk,
//               accepts stereo samples over valid/ready into a one-deep
//               holding register and serialises them MSB-first on SDATA,
//               which changes on BCK falling edges.
// Ports       : clk, reset (async, active high)
//               enable                 run frames / stop at frame boundary
//               sample_l, sample_r     stereo pair, two's complement
//               sample_valid/ready     handshake, transfer on valid&&ready
//               bck, lrck, sdata       I2S pins (registered)
//               underflow              one-clk pulse, frame began empty
// Config      : I2S_LEFT_JUSTIFIED_EN  defined  -> left-justified, L MSB in
//                                                  slot 0
//                                      undefined -> I2S, one-BCK delay
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx_sequencer
    import i2s_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BCK_HZ = 1_411_200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bck,
    output logic                lrck,
    output logic                sdata,
    output logic                underflow
);

    localparam int               c_div_half  = calc_div_half(CLK_HZ, BCK_HZ);
    localparam logic [CNT_W-1:0] c_last_slot = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] c_r_slot    = CNT_W'(SAMPLE_W);

    seq_state_t              r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_lrck;
    logic                    r_sdata;
    logic                    r_underflow;
    logic [SAMPLE_W-1:0]     r_hold_l;
    logic [SAMPLE_W-1:0]     r_hold_r;
    logic                    r_hold_full;
    logic [FRAME_BITS-1:0]   r_shift;

    logic                    w_bck;
    logic                    w_fall_tick;
    logic                    w_run;
    logic                    w_capture;
    logic                    w_last_slot;
    logic                    w_load;
    logic [CNT_W-1:0]        w_next_cnt;
    logic [FRAME_BITS-1:0]   w_frame;

    assign w_run       = (r_state == RUN);
    assign w_capture   = sample_valid && !r_hold_full;
    assign w_last_slot = (r_bit_cnt == c_last_slot);
    assign w_next_cnt  = r_bit_cnt + 1'b1;
    // A frame starts either leaving IDLE or wrapping slot 31 with enable
    // still high; both consume the holding register.
    assign w_load      = enable && (!w_run || (w_fall_tick && w_last_slot));
    // Empty holding register plays out silence for the whole frame.
    assign w_frame     = r_hold_full ? {r_hold_l, r_hold_r} : '0;

    i2s_bck_tick_gen #(
        .DIV_HALF (c_div_half)
    ) u_tick_gen (
        .clk         (clk),
        .reset       (reset),
        .i_run       (w_run),
        .o_bck       (w_bck),
        .o_fall_tick (w_fall_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_lrck      <= 1'b0;
            r_sdata     <= 1'b0;
            r_underflow <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
        end else begin
            r_underflow <= 1'b0;

            // Capture is only possible while empty, so a simultaneous frame
            // load has already seen "empty" and cannot reuse this pair.
            if (w_capture) begin
                r_hold_l    <= sample_l;
                r_hold_r    <= sample_r;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_lrck    <= 1'b0;
                    r_sdata   <= 1'b0;
                    if (enable) begin
                        r_state     <= RUN;
                        r_underflow <= !r_hold_full;
`ifdef I2S_LEFT_JUSTIFIED_EN
                        r_sdata     <= w_frame[FRAME_BITS-1];
                        r_shift     <= w_frame << 1;
`else
                        r_shift     <= w_frame;
`endif
                    end
                end

                RUN: begin
                    if (w_fall_tick) begin
                        if (w_last_slot) begin
                            r_bit_cnt <= '0;
                            r_lrck    <= 1'b0;
                            if (enable) begin
                                r_underflow <= !r_hold_full;
`ifdef I2S_LEFT_JUSTIFIED_EN
                                r_sdata     <= w_frame[FRAME_BITS-1];
                                r_shift     <= w_frame << 1;
`else
                                // Slot 0 carries the previous right LSB.
                                r_sdata     <= r_shift[FRAME_BITS-1];
                                r_shift     <= w_frame;
`endif
                            end else begin
                                r_state <= IDLE;
                                r_sdata <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= w_next_cnt;
                            r_lrck    <= (w_next_cnt >= c_r_slot);
                            r_sdata   <= r_shift[FRAME_BITS-1];
                            r_shift   <= r_shift << 1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign sample_ready = !r_hold_full;
    assign bck          = w_bck;
    assign lrck         = r_lrck;
    assign sdata        = r_sdata;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_sequencer.sv
// ============================================================================
// Module      : tb_i2s_tx_sequencer
// Description : Directed self-checking bench for i2s_tx_sequencer with
//               DIV_HALF = 4 (CLK_HZ=8, BCK_HZ=1). Every BCK rising edge
//               records {lrck, sdata}; frames are compared against
//               hand-computed words (slot 0 in bit 31). Expectations follow
//               I2S_LEFT_JUSTIFIED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx_sequencer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        bck;
    logic        lrck;
    logic        sdata;
    logic        underflow;

    int n_checks;
    int n_fail;

    logic [1:0] slots[$];
    int         uf_hi_cnt;
    int         uf_first_size;

    i2s_tx_sequencer #(
        .CLK_HZ (8),
        .BCK_HZ (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bck          (bck),
        .lrck         (lrck),
        .sdata        (sdata),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge bck) slots.push_back({lrck, sdata});

    always @(negedge clk) begin
        if (underflow === 1'b1) begin
            if (uf_hi_cnt == 0) uf_first_size = slots.size();
            uf_hi_cnt++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        int n;
        @(negedge clk);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        n = 0;
        while (sample_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_value("send_ready", {31'd0, sample_ready}, 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_slots(input int n);
        int k;
        k = 0;
        while (slots.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_value("wait_slots", slots.size(), n);
    endtask

    function automatic logic [31:0] frame_sd(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], slots[base+i][0]};
        return w;
    endfunction

    function automatic logic [31:0] frame_lr(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], slots[base+i][1]};
        return w;
    endfunction

    logic [31:0] exp_f0, exp_f1, exp_f2, exp_f3;

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        uf_hi_cnt     = 0;
        uf_first_size = -1;
        reset         = 1'b1;
        enable        = 1'b0;
        sample_l      = '0;
        sample_r      = '0;
        sample_valid  = 1'b0;

`ifdef I2S_LEFT_JUSTIFIED_EN
        exp_f0 = 32'hA5C3_0F0F;
        exp_f1 = 32'h0000_0000;
        exp_f2 = 32'h1234_5678;
        exp_f3 = 32'h9999_AAAA;
`else
        exp_f0 = {1'b0, 16'hA5C3, 15'h0787};
        exp_f1 = 32'h8000_0000;
        exp_f2 = {1'b0, 16'h1234, 15'h2B3C};
        exp_f3 = {1'b0, 16'h9999, 15'h5555};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_bck",   {31'd0, bck},          32'd0);
        check_value("rst_lrck",  {31'd0, lrck},         32'd0);
        check_value("rst_sdata", {31'd0, sdata},        32'd0);
        check_value("rst_uf",    {31'd0, underflow},    32'd0);
        check_value("rst_ready", {31'd0, sample_ready}, 32'd1);
        reset = 1'b0;
        slots.delete();
        uf_hi_cnt = 0;

        // Frame 0 data, frame 1 underflow
        send_pair(16'hA5C3, 16'h0F0F);
        check_value("ready_low_full", {31'd0, sample_ready}, 32'd0);
        enable = 1'b1;
        wait_slots(40);

        // Frame 2 pair, then a second pair held against a full register
        send_pair(16'h1234, 16'h5678);
        check_value("ready_low_held", {31'd0, sample_ready}, 32'd0);
        send_pair(16'h9999, 16'hAAAA);

        // Stop requested at slot 5 of frame 3
        wait_slots(96 + 6);
        enable = 1'b0;
        wait_slots(128);
        repeat (40) @(negedge clk);
        check_value("idle_slot_count", slots.size(), 128);
        check_value("idle_bck",   {31'd0, bck},   32'd0);
        check_value("idle_lrck",  {31'd0, lrck},  32'd0);
        check_value("idle_sdata", {31'd0, sdata}, 32'd0);

        check_value("f0_sdata", frame_sd(0),  exp_f0);
        check_value("f1_sdata", frame_sd(32), exp_f1);
        check_value("f2_sdata", frame_sd(64), exp_f2);
        check_value("f3_sdata", frame_sd(96), exp_f3);
        check_value("f0_lrck",  frame_lr(0),  32'h0000_FFFF);
        check_value("f1_lrck",  frame_lr(32), 32'h0000_FFFF);
        check_value("f2_lrck",  frame_lr(64), 32'h0000_FFFF);
        check_value("f3_lrck",  frame_lr(96), 32'h0000_FFFF);
        check_value("uf_clk_width", uf_hi_cnt, 1);
        check_value("uf_at_frame1", uf_first_size, 32);

        // Restart, then asynchronous reset in the middle of the right word
        send_pair(16'h1111, 16'hC222);
        enable = 1'b1;
        wait_slots(128 + 2);
        send_pair(16'h3333, 16'h4444);
        wait_slots(128 + 18);
        check_value("mid_bck",   {31'd0, bck},          32'd1);
        check_value("mid_lrck",  {31'd0, lrck},         32'd1);
        check_value("mid_sdata", {31'd0, sdata},        32'd1);
        check_value("mid_ready", {31'd0, sample_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_value("arst_bck",   {31'd0, bck},          32'd0);
        check_value("arst_lrck",  {31'd0, lrck},         32'd0);
        check_value("arst_sdata", {31'd0, sdata},        32'd0);
        check_value("arst_uf",    {31'd0, underflow},    32'd0);
        check_value("arst_ready", {31'd0, sample_ready}, 32'd1);
        check_value("restart_no_uf", uf_hi_cnt, 1);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_value("post_rst_ready", {31'd0, sample_ready}, 32'd1);
        check_value("post_rst_bck",   {31'd0, bck},          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
